// File: rtl/ber_window_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ber_window_meter_pkg
// Brief    : Shared constants, FSM encoding and 8-bit popcount for the BER meter
// Revision : 1.0
// ============================================================================
package ber_window_meter_pkg;

    localparam logic [63:0] RATE_SCALE = 64'd1_000_000_000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ber_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : ber_seq_divider
// Brief    : 64/32 restoring divider, one quotient bit per cycle, 32 cycles
// Revision : 1.0
// ============================================================================
module ber_seq_divider (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [63:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient
);

    logic [31:0] r_rem;
    logic [31:0] r_lo;
    logic [31:0] r_divisor;
    logic [4:0]  r_cnt;
    logic        r_busy;

    logic [32:0] w_trial;
    logic        w_ge;
    logic [31:0] w_diff;

    // Caller guarantees dividend[63:32] < divisor, so the quotient fits 32 bits
    // and the running remainder never needs more than 32 bits.
    always_comb begin
        w_trial = {r_rem, r_lo[31]};
        w_ge    = (w_trial >= {1'b0, r_divisor});
        w_diff  = w_trial[31:0] - r_divisor;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rem     <= '0;
            r_lo      <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
        end else if (start) begin
            r_rem     <= dividend[63:32];
            r_lo      <= dividend[31:0];
            r_divisor <= divisor;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
        end else if (r_busy) begin
            r_rem <= w_ge ? w_diff : w_trial[31:0];
            r_lo  <= {r_lo[30:0], w_ge};
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
                r_busy <= 1'b0;
            end
        end
    end

    // High during the final iteration; quotient is complete after that edge.
    assign done     = r_busy && (r_cnt == 5'd31);
    assign quotient = r_lo;

endmodule
`default_nettype wire

// File: rtl/ber_window_meter.sv
`default_nettype none
// ============================================================================
// Module   : ber_window_meter
// Brief    : Windowed bit-error counter producing an error rate in units of 1e-9
// Revision : 1.0
// ============================================================================
module ber_window_meter
    import ber_window_meter_pkg::*;
#(
    parameter int unsigned WINDOW_BITS = 1_000_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        valid_i,
    input  logic [7:0]  sent_data,
    input  logic [7:0]  recv_data,
    input  logic [3:0]  number_of_bits,
    output logic [31:0] error_rate,
    output logic        valid_o,
    output logic        busy,
    output logic        overrun
);

    logic [31:0] r_bit_cnt;
    logic [31:0] r_err_cnt;
    logic [31:0] r_bit_snap;
    logic [31:0] r_err_snap;
    state_t      r_state;
    state_t      w_state_next;

    logic        w_accept;
    logic        w_close;
    logic [7:0]  w_mask;
    logic [3:0]  w_errs;
    logic [31:0] w_bit_next;
    logic [31:0] w_err_next;
    logic [63:0] w_dividend;
    logic        w_div_start;
    logic        w_div_done;
    logic [31:0] w_quotient;

    always_comb begin
        w_accept   = valid_i && (number_of_bits != 4'd0) && (number_of_bits <= 4'd8);
        w_mask     = 8'hFF >> (4'd8 - number_of_bits);
        w_errs     = popcount8((sent_data ^ recv_data) & w_mask);
        w_bit_next = r_bit_cnt + {28'd0, number_of_bits};
        w_err_next = r_err_cnt + {28'd0, w_errs};
        w_close    = w_accept && (w_bit_next >= WINDOW_BITS);
        w_dividend = {32'd0, r_err_snap} * RATE_SCALE;
    end

    // Accumulation runs regardless of the FSM; a closing beat is fully counted.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_bit_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_close) begin
            r_bit_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_accept) begin
            r_bit_cnt <= w_bit_next;
            r_err_cnt <= w_err_next;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_bit_snap <= '0;
            r_err_snap <= '0;
            overrun    <= 1'b0;
        end else if (w_close) begin
            if (r_state == ST_IDLE) begin
                r_bit_snap <= w_bit_next;
                r_err_snap <= w_err_next;
            end else begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_div_start  = 1'b0;
        case (r_state)
            ST_IDLE: if (w_close) w_state_next = ST_LOAD;
            ST_LOAD: begin
                w_div_start  = 1'b1;
                w_state_next = ST_DIV;
            end
            ST_DIV:  if (w_div_done) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    ber_seq_divider u_divider (
        .CLK      (CLK),
        .RST      (RST),
        .start    (w_div_start),
        .dividend (w_dividend),
        .divisor  (r_bit_snap),
        .done     (w_div_done),
        .quotient (w_quotient)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            error_rate <= '0;
            valid_o    <= 1'b0;
        end else begin
            valid_o <= (r_state == ST_DONE);
            if (r_state == ST_DONE) begin
                error_rate <= w_quotient;
            end
        end
    end

    assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/ber_window_meter.md
# ber_window_meter

Upstream stage of the LCD bit-error-rate display path. Compares each transmitted/received byte pair, counts bit errors over a fixed window of compared bits, and converts the closed window into a 32-bit error rate in units of 1e-9. It feeds the number-to-character converter (`error_rate`, `valid_o`); the LCD top instantiates it in place of its constant test value.

## Interface
- `WINDOW_BITS`, default 1_000_000: compared bits per measurement window. Legal range 1..2^31.
- `CLK`  in  1  single clock; all state changes on rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  one compare beat per cycle when high.
- `sent_data`  in  8  transmitted byte.
- `recv_data`  in  8  received byte.
- `number_of_bits`  in  4  valid LSBs of the byte pair (1..8).
- `error_rate`  out  32  errors × 1e9 / bits of last window, truncated.
- `valid_o`  out  1  one-cycle pulse: `error_rate` updated.
- `busy`  out  1  high while a rate is being computed.
- `overrun`  out  1  sticky: a window closed while `busy`.

## Operation
- Beat accepted when `valid_i`=1 and `number_of_bits` in 1..8. Values 0 and 9..15 are ignored: no count change.
- Per beat: mask = low `number_of_bits` bits; errs = popcount((sent^recv)&mask); `bit_cnt` += `number_of_bits`, `err_cnt` += errs. Both counters 32-bit.
- Window closes on the beat where the updated `bit_cnt` ≥ `WINDOW_BITS`. That beat is included in full, so the denominator may exceed `WINDOW_BITS` by up to 7. The (updated) `bit_cnt`/`err_cnt` are snapshotted, and both counters restart at 0 on the same edge.
- Accumulation never stalls; it continues during computation.
- FSM:
  - IDLE: waits for a window close, then goes to LOAD.
  - LOAD: dividend = err_snap × 1_000_000_000 as a 64-bit constant multiply; divisor = bit_snap. Goes to DIV.
  - DIV: 32 restoring-division iterations, 1 per cycle. The quotient is the low 32 bits; the dividend is < 2^62, so the quotient is ≤ 1e9. Goes to DONE.
  - DONE: registers the quotient into `error_rate`, pulses `valid_o`, and returns to IDLE.
- The divisor is never 0 because the snapshot is ≥ 1.
- `busy` = state ≠ IDLE.
- A window close while `busy`:
  - the snapshot is discarded;
  - the counters still restart;
  - `overrun` is set to 1.
  - `overrun` clears only on reset.

## Timing
- Reset values: `error_rate`=0, `valid_o`=0, `busy`=0, `overrun`=0, counters 0, state IDLE.
- Reset mid-computation aborts immediately. No `valid_o` follows.
- Closing beat sampled at edge k. Then:
  - LOAD at edge k+1;
  - DIV iterations at edges k+2..k+33;
  - DONE→IDLE at edge k+34, with `error_rate` and `valid_o` updated at that edge.
- `valid_o` is high for exactly the one cycle after edge k+34. `error_rate` holds until the next update.
- Minimum spacing between accepted windows: 35 cycles. Closer spacing produces `overrun`.
- A beat arriving on the same edge as DONE is accumulated normally into the current window.

## Structure
- Shared package/header:
  - `RATE_SCALE` = 1_000_000_000;
  - FSM state encoding {IDLE, LOAD, DIV, DONE};
  - popcount function for 8 bits.
- Sub-module `ber_seq_divider`: 64/32 restoring divider with start/done, 32 cycles, 32-bit quotient. The top holds the counters, snapshot, FSM and output registers.

## Test plan
- WINDOW_BITS=80: 10 beats, n=8, sent=recv → `error_rate`=0 and `valid_o` once, 34 cycles after the 10th beat edge.
- WINDOW_BITS=80: 10 beats, n=8, sent=0x00, recv=0xFF → `error_rate`=1_000_000_000.
- WINDOW_BITS=1000: 125 beats, n=8, one beat with a single-bit mismatch → `error_rate`=1_000_000.
- WINDOW_BITS=10: n=3, 4 beats each with sent^recv=0xF8 plus one beat with 0x01. Closes at 12 bits with 1 error → 83_333_333. Upper mask bits are ignored. An n=0 beat mid-stream changes nothing.
- WINDOW_BITS=8: n=8 beats every cycle → second close within 35 cycles. Expect `overrun`=1, one `valid_o` for the first window, and the dropped window never reported.
- `RST` low during DIV → outputs return to 0 asynchronously. No `valid_o` follows. The next full window reports correctly.
